// File: rtl/sram_arb_if.sv
// Request/response bundle between the three client ports, the arbiter and the
// single-access SDRAM controller. The arbiter uses the slave view; the
// clients and the controller side together form the master view.
interface sram_arb_if;
  // video fetch port (read-only)
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_dout;

  // CPU (Wishbone bridge) port
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_sel;
  logic        cpu_ack;
  logic [15:0] cpu_dout;

  // memory-copy / loader port (writes are always full-word)
  logic        cpy_req;
  logic        cpy_we;
  logic [23:0] cpy_addr;
  logic [15:0] cpy_din;
  logic        cpy_ack;
  logic [15:0] cpy_dout;

  // controller side
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_wtbt;
  logic        mem_we;
  logic        mem_rd;
  logic [15:0] mem_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_sel,
    input  cpy_req, cpy_we, cpy_addr, cpy_din,
    input  mem_dout,
    output vid_ack, vid_dout,
    output cpu_ack, cpu_dout,
    output cpy_ack, cpy_dout,
    output mem_addr, mem_din, mem_wtbt, mem_we, mem_rd
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_sel,
    output cpy_req, cpy_we, cpy_addr, cpy_din,
    output mem_dout,
    input  vid_ack, vid_dout,
    input  cpu_ack, cpu_dout,
    input  cpy_ack, cpy_dout,
    input  mem_addr, mem_din, mem_wtbt, mem_we, mem_rd
  );
endinterface

// File: rtl/sram_arb.sv
// Three-port scheduler in front of the single-access SDRAM controller.
// Serialises video, CPU and copy accesses onto the controller's edge-triggered
// rd/we strobes using a fixed strobe + access window, since the controller has
// no completion signal. Video has priority, bounded by a burst limit; CPU and
// copy share a round-robin slot.
module sram_arb #(
  parameter int STROBE_CYCLES = 4,
  parameter int ACCESS_CYCLES = 28,
  parameter int VID_BURST     = 4
) (
  input  logic       clk_ram,
  input  logic       init_n,
  sram_arb_if.slave  bus,
  output logic       busy,
  output logic [1:0] grant
);

  localparam int CNT_MAX = (STROBE_CYCLES > ACCESS_CYCLES) ? STROBE_CYCLES : ACCESS_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int VID_W   = $clog2(VID_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_VID  = 2'd1,
    P_CPU  = 2'd2,
    P_CPY  = 2'd3
  } port_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  // arbitration state: rr_ptr 0 = cpu next, 1 = cpy next
  logic              rr_ptr;
  logic [VID_W-1:0]  vid_run;
  logic              other_pend;
  port_t             rr_win;
  port_t             win;
  logic              win_we;
  logic              grant_take;

  // latched access
  port_t             grant_r;
  logic              acc_we;
  logic [23:0]       mem_addr_r;
  logic [15:0]       mem_din_r;
  logic [1:0]        mem_wtbt_r;
  logic              mem_we_r;
  logic              mem_rd_r;

  logic              vid_ack_r;
  logic              cpu_ack_r;
  logic              cpy_ack_r;
  logic [15:0]       vid_dout_r;
  logic [15:0]       cpu_dout_r;
  logic [15:0]       cpy_dout_r;

  // Winner selection: video first unless it has used up its burst while a
  // CPU/copy request waits; CPU vs copy by round-robin pointer.
  always_comb begin
    other_pend = bus.cpu_req | bus.cpy_req;
    rr_win     = P_NONE;
    win        = P_NONE;
    win_we     = 1'b0;
    if (bus.cpu_req && (!rr_ptr || !bus.cpy_req)) begin
      rr_win = P_CPU;
    end else if (bus.cpy_req) begin
      rr_win = P_CPY;
    end
    if (bus.vid_req && !(other_pend && (vid_run == VID_W'(VID_BURST)))) begin
      win = P_VID;
    end else begin
      win = rr_win;
    end
    case (win)
      P_CPU:   win_we = bus.cpu_we;
      P_CPY:   win_we = bus.cpy_we;
      default: win_we = 1'b0;
    endcase
  end

  // Requests are only looked at in IDLE; later arrivals wait their turn.
  assign grant_take = (state == S_IDLE) && (win != P_NONE);

  // Access sequencer state register.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Access sequencer next state: fixed-length strobe, then fixed wait window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (grant_take) begin
          state_nxt = S_ISSUE;
          cnt_nxt   = '0;
        end
      end
      S_ISSUE: begin
        if (cnt == CNT_W'(STROBE_CYCLES - 1)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt == CNT_W'(ACCESS_CYCLES - 1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Round-robin pointer and video run counter, updated only on IDLE decisions.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      rr_ptr  <= 1'b0;
      vid_run <= '0;
    end else if (grant_take && (win != P_VID)) begin
      rr_ptr  <= (win == P_CPU);
      vid_run <= '0;
    end else if (grant_take && other_pend) begin
      vid_run <= vid_run + VID_W'(1);
    end else if ((state == S_IDLE) && !other_pend) begin
      vid_run <= '0;
    end
  end

  // Latch the winner's address, data and byte enables; hold until next grant.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      grant_r    <= P_NONE;
      acc_we     <= 1'b0;
      mem_addr_r <= '0;
      mem_din_r  <= '0;
      mem_wtbt_r <= 2'b11;
    end else if (grant_take) begin
      grant_r <= win;
      acc_we  <= win_we;
      case (win)
        P_VID: begin
          mem_addr_r <= bus.vid_addr;
          mem_wtbt_r <= 2'b11;
        end
        P_CPU: begin
          mem_addr_r <= bus.cpu_addr;
          mem_din_r  <= bus.cpu_din;
          mem_wtbt_r <= bus.cpu_we ? bus.cpu_sel : 2'b11;
        end
        P_CPY: begin
          mem_addr_r <= bus.cpy_addr;
          mem_din_r  <= bus.cpy_din;
          mem_wtbt_r <= 2'b11;
        end
        default: ;
      endcase
    end else if (state == S_DONE) begin
      grant_r <= P_NONE;
    end
  end

  // Strobes are high exactly while ISSUE lasts; reset drops them at once.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      mem_we_r <= 1'b0;
      mem_rd_r <= 1'b0;
    end else if (grant_take) begin
      mem_we_r <= win_we;
      mem_rd_r <= !win_we;
    end else if (state_nxt != S_ISSUE) begin
      mem_we_r <= 1'b0;
      mem_rd_r <= 1'b0;
    end
  end

  // One-cycle acknowledge to the owner; reads also capture controller data.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      vid_ack_r  <= 1'b0;
      cpu_ack_r  <= 1'b0;
      cpy_ack_r  <= 1'b0;
      vid_dout_r <= '0;
      cpu_dout_r <= '0;
      cpy_dout_r <= '0;
    end else begin
      vid_ack_r <= (state == S_DONE) && (grant_r == P_VID);
      cpu_ack_r <= (state == S_DONE) && (grant_r == P_CPU);
      cpy_ack_r <= (state == S_DONE) && (grant_r == P_CPY);
      if ((state == S_DONE) && !acc_we) begin
        case (grant_r)
          P_VID:   vid_dout_r <= bus.mem_dout;
          P_CPU:   cpu_dout_r <= bus.mem_dout;
          P_CPY:   cpy_dout_r <= bus.mem_dout;
          default: ;
        endcase
      end
    end
  end

  // Busy flag tracks the sequencer leaving IDLE.
  always_ff @(posedge clk_ram or negedge init_n) begin
    if (!init_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
    end
  end

  assign grant        = grant_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_din  = mem_din_r;
  assign bus.mem_wtbt = mem_wtbt_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_rd   = mem_rd_r;
  assign bus.vid_ack  = vid_ack_r;
  assign bus.cpu_ack  = cpu_ack_r;
  assign bus.cpy_ack  = cpy_ack_r;
  assign bus.vid_dout = vid_dout_r;
  assign bus.cpu_dout = cpu_dout_r;
  assign bus.cpy_dout = cpy_dout_r;

endmodule
